mips_muldiv: RTL and testbench
==============================

# mips_muldiv

Iterative multiply/divide unit with HI/LO result registers for the MIPS Harvard CPU. It executes MULT, MULTU, DIV and DIVU over a parametrised operand width and is controlled by a start/busy/done handshake. It also serves MTHI/MTLO writes and continuously exposes HI/LO for MFHI/MFLO. It sits beside the ALU in the execute stage and honours the CPU-wide `clk_enable` stall.

## Interface
- `WIDTH`, 32: operand width and HI/LO width; minimum 2.
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `clk_enable`  in  1  global stall; low freezes every register.
- `start`  in  1  launch operation; sampled only in IDLE.
- `op`  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `a`, `b`  in  WIDTH  rs/rt operands; sampled with `start`.
- `hi_we`, `lo_we`  in  1  MTHI/MTLO write strobes.
- `wdata`  in  WIDTH  MTHI/MTLO data.
- `busy`  out  1  operation in progress.
- `done`  out  1  one-cycle pulse: HI/LO just updated by an operation.
- `div_by_zero`  out  1  pulses with `done` when DIV/DIVU had `b`=0.
- `hi`, `lo`  out  WIDTH  result registers.

## Operation
- Reset values: `hi`=0, `lo`=0, `busy`=0, `done`=0, `div_by_zero`=0, state IDLE.
- States: IDLE -> RUN (on `start`) -> FIXUP -> IDLE. RUN lasts exactly WIDTH cycles. FIXUP lasts 1 cycle.
- Signed ops take the magnitudes of `a` and `b` at start and record the result signs.
- Multiply: shift-add, one bit per RUN cycle, over a 2*WIDTH accumulator. FIXUP negates the product if the signs differ. HI = upper WIDTH bits, LO = lower WIDTH bits.
- Divide: restoring, one quotient bit per RUN cycle. FIXUP applies signs. The quotient truncates toward zero, and the remainder takes the sign of the dividend. LO = quotient, HI = remainder.
- Divide by zero: same latency. LO = all ones, HI = `a` unmodified. `div_by_zero`=1 with `done`.
- Signed overflow (most-negative / -1): LO = most-negative, HI = 0. No flag.
- `start` while busy: ignored.
- `hi_we`/`lo_we` in IDLE write `wdata` at the next edge. Both may be asserted together.
- `hi_we`/`lo_we` while busy: ignored.
- `start` together with `hi_we`/`lo_we` in IDLE: `start` wins and the writes are dropped.
- HI/LO change only at the FIXUP->IDLE edge or on an MTHI/MTLO write. They keep their old values throughout RUN.

## Timing
- Cycle 0: `start` is high in IDLE with `clk_enable`=1. `a`, `b` and `op` are captured at the edge ending cycle 0.
- Cycles 1..WIDTH: RUN, with `busy`=1.
- Cycle WIDTH+1: FIXUP, with `busy`=1.
- Cycle WIDTH+2: IDLE. `busy`=0, `done`=1, and HI/LO hold the new results. For WIDTH=32, `done` is seen in cycle 34.
- A new `start` is accepted in the same cycle that `done` is high.
- `clk_enable`=0: state, counters, HI/LO and the `done`/`div_by_zero` outputs all hold. The pulse stretches across stalled cycles, and total latency grows by exactly the number of stalled cycles.
- `reset` mid-operation: at the next edge the block returns to IDLE with all outputs at their reset values. The aborted result is discarded.
- `reset` takes precedence over `clk_enable`.
- `hi`/`lo` are plain register outputs with no combinational path from the inputs.

## Structure
- Package `mips_muldiv_pkg` holds:
  - the `op` enum: MULT, MULTU, DIV, DIVU;
  - the state enum: IDLE, RUN, FIXUP;
  - the width of the RUN iteration counter, `$clog2(WIDTH+1)`.
- Sub-module `mips_muldiv_sign`: combinational conditional two's-complement negate, parametrised by WIDTH. It is instantiated for the operand magnitudes and for the FIXUP sign correction.
- All remaining datapath and control live in `mips_muldiv`.

## Test plan
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> `hi`=0xFFFFFFFE, `lo`=0x00000001, `done` in cycle 34, `busy` high in cycles 1-33.
- MULT -3 x 5 -> `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF1. Then MTHI 0x1234 -> `hi`=0x1234 next cycle, `lo` unchanged.
- DIV -7 / 2 -> `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. DIVU 7 / 2 -> `lo`=3, `hi`=1.
- DIVU 7 / 0 -> `lo`=0xFFFFFFFF, `hi`=7, `div_by_zero`=1 with `done`. DIV 0x80000000 / 0xFFFFFFFF -> `lo`=0x80000000, `hi`=0, flag 0.
- `clk_enable` low for 5 cycles during RUN -> `done` arrives in cycle 39. In addition, `start` re-asserted during RUN and `lo_we` asserted during RUN are both ignored, and `lo` matches the first operation's result.
- Start MULTU with `hi`=`lo`=0x55, then assert `reset` in cycle 10 -> cycle 11 has `busy`=0 and `hi`=`lo`=0, and no `done` ever follows. Repeat with WIDTH=8: 0xFF x 0xFF -> `hi`=0xFE, `lo`=0x01, `done` in cycle 10.

Source files
------------

// File: rtl/mips_muldiv_pkg.sv
// Purpose: shared types for the iterative MIPS multiply/divide unit.
// Latency: n/a (types, constants and a width helper only).
// Backpressure: n/a.
package mips_muldiv_pkg;

    // Encoding matches the 2-bit op field driven by the decoder.
    typedef enum logic [1:0] {
        MULT  = 2'b00,
        MULTU = 2'b01,
        DIV   = 2'b10,
        DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        FIXUP = 2'b10
    } state_e;

    // Width of the RUN iteration counter for a given operand width.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/mips_muldiv_sign.sv
// Purpose: conditional two's-complement negate (val_o = neg_i ? -val_i : val_i).
// Latency: combinational, zero cycles.
// Backpressure: none.
// Ports: neg_i selects negation, val_i operand, val_o result (all WIDTH bits wide).
module mips_muldiv_sign
    import mips_muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             neg_i,
    input  logic [WIDTH-1:0] val_i,
    output logic [WIDTH-1:0] val_o
);

    assign val_o = neg_i ? (~val_i + WIDTH'(1)) : val_i;

endmodule

// File: rtl/mips_muldiv.sv
// Purpose: iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers and MTHI/MTLO writes.
// Latency: start in cycle 0 -> done (HI/LO updated) in cycle WIDTH+2; stalls add 1:1.
// Backpressure: start ignored while busy; clk_enable low freezes every register.
// Ports: clk/reset (sync, active-high), clk_enable_i stall, start_i/op_i/a_i/b_i launch,
//        hi_we_i/lo_we_i/wdata_i MTHI/MTLO, busy_o/done_o/div_by_zero_o status, hi_o/lo_o results.
module mips_muldiv
    import mips_muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_enable_i,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             hi_we_i,
    input  logic             lo_we_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             div_by_zero_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int CW = cnt_width(WIDTH);

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    // Multiply: {partial product, remaining multiplier bits}.
    // Divide:   {partial remainder, remaining dividend / quotient bits}.
    logic [2*WIDTH-1:0] acc_q, acc_d;
    // Multiplicand magnitude (multiply) or divisor magnitude (divide).
    logic [WIDTH-1:0]   den_q, den_d;
    // Raw dividend, returned untouched in HI on divide by zero.
    logic [WIDTH-1:0]   araw_q, araw_d;
    logic               is_div_q, is_div_d;
    logic               neg_res_q, neg_res_d;   // product / quotient sign
    logic               neg_rem_q, neg_rem_d;   // remainder sign (dividend sign)
    logic               bzero_q, bzero_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               done_q, done_d, dbz_q, dbz_d;

    op_e                op_s;
    logic               signed_op, div_op;
    logic [WIDTH-1:0]   a_mag, b_mag, addend, quo_fix, rem_fix;
    logic [WIDTH:0]     msum, rem_sh, diff;
    logic [2*WIDTH-1:0] mul_next, div_next, prod_fix;

    assign op_s      = op_e'(op_i);
    assign signed_op = (op_s == MULT) || (op_s == DIV);
    assign div_op    = (op_s == DIV) || (op_s == DIVU);

    mips_muldiv_sign #(.WIDTH(WIDTH)) u_amag (
        .neg_i(signed_op & a_i[WIDTH-1]), .val_i(a_i), .val_o(a_mag));
    mips_muldiv_sign #(.WIDTH(WIDTH)) u_bmag (
        .neg_i(signed_op & b_i[WIDTH-1]), .val_i(b_i), .val_o(b_mag));
    mips_muldiv_sign #(.WIDTH(2*WIDTH)) u_prod (
        .neg_i(neg_res_q), .val_i(acc_q), .val_o(prod_fix));
    mips_muldiv_sign #(.WIDTH(WIDTH)) u_quot (
        .neg_i(neg_res_q), .val_i(acc_q[WIDTH-1:0]), .val_o(quo_fix));
    mips_muldiv_sign #(.WIDTH(WIDTH)) u_rem (
        .neg_i(neg_rem_q), .val_i(acc_q[2*WIDTH-1:WIDTH]), .val_o(rem_fix));

    // Shift-add step: add multiplicand when the current multiplier LSB is set,
    // then shift the whole accumulator right, carry included.
    assign addend   = acc_q[0] ? den_q : {WIDTH{1'b0}};
    assign msum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};
    assign mul_next = {msum, acc_q[WIDTH-1:1]};

    // Restoring step: bring in the next dividend bit, try a subtract, keep it
    // only if it did not borrow. The remainder always stays below the divisor,
    // so a zero divisor naturally yields an all-ones quotient (overridden later).
    assign rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign diff     = rem_sh - {1'b0, den_q};
    assign div_next = diff[WIDTH] ? {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                  : {diff[WIDTH-1:0],   acc_q[WIDTH-2:0], 1'b1};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        den_d     = den_q;
        araw_d    = araw_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        bzero_d   = bzero_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        dbz_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d   = RUN;
                    cnt_d     = '0;
                    araw_d    = a_i;
                    is_div_d  = div_op;
                    bzero_d   = (b_i == {WIDTH{1'b0}});
                    neg_res_d = signed_op & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
                    neg_rem_d = signed_op & a_i[WIDTH-1];
                    if (div_op) begin
                        acc_d = {{WIDTH{1'b0}}, a_mag};
                        den_d = b_mag;
                    end else begin
                        acc_d = {{WIDTH{1'b0}}, b_mag};
                        den_d = a_mag;
                    end
                end else begin
                    if (hi_we_i) hi_d = wdata_i;
                    if (lo_we_i) lo_d = wdata_i;
                end
            end
            RUN: begin
                acc_d = is_div_q ? div_next : mul_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) state_d = FIXUP;
            end
            FIXUP: begin
                state_d = IDLE;
                done_d  = 1'b1;
                dbz_d   = is_div_q & bzero_q;
                if (!is_div_q) begin
                    {hi_d, lo_d} = prod_fix;
                end else if (bzero_q) begin
                    hi_d = araw_q;
                    lo_d = {WIDTH{1'b1}};
                end else begin
                    // Most-negative / -1 wraps to most-negative with zero remainder.
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            den_q     <= '0;
            araw_q    <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            bzero_q   <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
        end else if (clk_enable_i) begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            den_q     <= den_d;
            araw_q    <= araw_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            bzero_q   <= bzero_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
            dbz_q     <= dbz_d;
        end
    end

    assign busy_o        = (state_q != IDLE);
    assign done_o        = done_q;
    assign div_by_zero_o = dbz_q;
    assign hi_o          = hi_q;
    assign lo_o          = lo_q;

endmodule

// File: tb/tb_mips_muldiv.sv
// Purpose: self-checking bench for mips_muldiv at WIDTH=32 and WIDTH=8.
// Latency: checks done arrives WIDTH+2 cycles after start, plus stalled cycles.
// Backpressure: exercises clk_enable stalls, start/MTLO while busy, reset abort.
module tb_mips_muldiv;

    logic        clk = 1'b0;
    logic        reset, clk_enable, start, hi_we, lo_we, sel8;
    logic [1:0]  op;
    logic [31:0] a, b, wdata;

    logic        busy32, done32, dbz32, busy8, done8, dbz8;
    logic [31:0] hi32, lo32;
    logic [7:0]  hi8, lo8;
    logic        busy_m, done_m, dbz_m;
    logic [31:0] hi_m, lo_m;

    int n_pass = 0;
    int n_chk  = 0;

    always #5 clk = ~clk;

    mips_muldiv #(.WIDTH(32)) u_dut32 (
        .clk(clk), .reset(reset), .clk_enable_i(clk_enable),
        .start_i(start & ~sel8), .op_i(op), .a_i(a), .b_i(b),
        .hi_we_i(hi_we & ~sel8), .lo_we_i(lo_we & ~sel8), .wdata_i(wdata),
        .busy_o(busy32), .done_o(done32), .div_by_zero_o(dbz32),
        .hi_o(hi32), .lo_o(lo32));

    mips_muldiv #(.WIDTH(8)) u_dut8 (
        .clk(clk), .reset(reset), .clk_enable_i(clk_enable),
        .start_i(start & sel8), .op_i(op), .a_i(a[7:0]), .b_i(b[7:0]),
        .hi_we_i(hi_we & sel8), .lo_we_i(lo_we & sel8), .wdata_i(wdata[7:0]),
        .busy_o(busy8), .done_o(done8), .div_by_zero_o(dbz8),
        .hi_o(hi8), .lo_o(lo8));

    assign busy_m = sel8 ? busy8 : busy32;
    assign done_m = sel8 ? done8 : done32;
    assign dbz_m  = sel8 ? dbz8  : dbz32;
    assign hi_m   = sel8 ? {24'h0, hi8} : hi32;
    assign lo_m   = sel8 ? {24'h0, lo8} : lo32;

    typedef struct {
        bit          w8;
        logic [1:0]  op;
        logic [31:0] a, b, hi, lo;
        logic        dbz;
    } vec_t;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        else n_pass++;
    endtask

    // Reference: plain integer arithmetic on sign-extended values.
    task automatic model(input int w, input logic [1:0] o, input logic [31:0] x, y,
                         output logic [31:0] eh, el, output logic ed);
        longint m, xx, yy, sx, sy, p, q, r;
        m  = (longint'(1) << w) - 1;
        xx = longint'(x) & m;
        yy = longint'(y) & m;
        sx = xx[w-1] ? xx - (m + 1) : xx;
        sy = yy[w-1] ? yy - (m + 1) : yy;
        ed = 1'b0;
        q  = 0;
        r  = 0;
        if (o[1] == 1'b0) begin
            p  = (o == 2'b00) ? sx * sy : xx * yy;
            eh = 32'((p >>> w) & m);
            el = 32'(p & m);
        end else begin
            if (yy == 0) begin
                q  = m;
                r  = xx;
                ed = 1'b1;
            end else if (o == 2'b11) begin
                q = xx / yy;
                r = xx % yy;
            end else if (sx == -(longint'(1) << (w - 1)) && sy == -1) begin
                q = sx;
                r = 0;
            end else begin
                q = sx / sy;
                r = sx % sy;
            end
            eh = 32'(r & m);
            el = 32'(q & m);
        end
    endtask

    function automatic logic [31:0] pick(input int w);
        logic [31:0] v;
        logic [31:0] msk;
        msk = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_00FF;
        case ($urandom_range(0, 5))
            0:       v = 32'h0;
            1:       v = 32'h1;
            2:       v = 32'hFFFF_FFFF;
            3:       v = (w == 32) ? 32'h8000_0000 : 32'h80;
            4:       v = $urandom_range(0, 20);
            default: v = $urandom;
        endcase
        return v & msk;
    endfunction

    // Launch one operation, watch busy/HI/LO until done, then check results.
    task automatic run_op(input string nm, input bit w8, input logic [1:0] o,
                          input logic [31:0] x, y, eh, el, input logic ed,
                          input int stall_at, input int stall_n, input bit poke);
        int lat, busy_bad, hold_bad, exp_lat;
        logic [31:0] prev_hi, prev_lo;
        sel8    = w8;
        exp_lat = (w8 ? 8 : 32) + 2 + stall_n;
        #0;
        prev_hi = hi_m;
        prev_lo = lo_m;
        start = 1'b1; op = o; a = x; b = y;
        step();
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        a = $urandom; b = $urandom;
        lat = 1; busy_bad = 0; hold_bad = 0;
        while (!done_m && lat < 200) begin
            if (!busy_m) busy_bad++;
            if (hi_m !== prev_hi || lo_m !== prev_lo) hold_bad++;
            if (lat == stall_at) clk_enable = 1'b0;
            if (lat == stall_at + stall_n) clk_enable = 1'b1;
            if (poke && lat == 5) begin start = 1'b1; lo_we = 1'b1; wdata = $urandom; end
            if (poke && lat == 6) begin start = 1'b0; lo_we = 1'b0; end
            step();
            lat++;
        end
        if (busy_m) busy_bad++;
        chk({nm, ".latency"}, lat, exp_lat);
        chk({nm, ".busy"}, busy_bad, 0);
        chk({nm, ".hold"}, hold_bad, 0);
        chk({nm, ".hi"}, hi_m, eh);
        chk({nm, ".lo"}, lo_m, el);
        chk({nm, ".dbz"}, dbz_m, ed);
    endtask

    vec_t vecs[12];

    initial begin
        logic [31:0] eh, el, x, y;
        logic        ed;
        logic [1:0]  o;
        int          cnt;
        bit          seen;

        vecs[0]  = '{1'b0, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
        vecs[1]  = '{1'b0, 2'b00, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0};
        vecs[2]  = '{1'b0, 2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
        vecs[3]  = '{1'b0, 2'b11, 32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003, 1'b0};
        vecs[4]  = '{1'b0, 2'b11, 32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF, 1'b1};
        vecs[5]  = '{1'b0, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
        vecs[6]  = '{1'b0, 2'b10, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1};
        vecs[7]  = '{1'b0, 2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
        vecs[8]  = '{1'b0, 2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0};
        vecs[9]  = '{1'b1, 2'b01, 32'h0000_00FF, 32'h0000_00FF, 32'h0000_00FE, 32'h0000_0001, 1'b0};
        vecs[10] = '{1'b1, 2'b10, 32'h0000_0080, 32'h0000_00FF, 32'h0000_0000, 32'h0000_0080, 1'b0};
        vecs[11] = '{1'b1, 2'b10, 32'h0000_00F9, 32'h0000_0000, 32'h0000_00F9, 32'h0000_00FF, 1'b1};

        reset = 1'b1; clk_enable = 1'b1; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        sel8 = 1'b0; op = 2'b00; a = '0; b = '0; wdata = '0;
        step(); step();
        reset = 1'b0;
        chk("reset.busy", busy32, 1'b0);
        chk("reset.done", done32, 1'b0);
        chk("reset.dbz", dbz32, 1'b0);
        chk("reset.hi", hi32, 32'h0);
        chk("reset.lo", lo32, 32'h0);
        chk("reset.hilo8", {busy8, done8, hi8, lo8}, 18'h0);

        foreach (vecs[i])
            run_op($sformatf("vec%0d", i), vecs[i].w8, vecs[i].op, vecs[i].a, vecs[i].b,
                   vecs[i].hi, vecs[i].lo, vecs[i].dbz, -1, 0, 1'b0);
        step();
        chk("done_pulse", done_m, 1'b0);

        // MULT then MTHI, then MTHI+MTLO together.
        run_op("mult_mthi", 1'b0, 2'b00, 32'hFFFF_FFFD, 32'h5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, -1, 0, 1'b0);
        hi_we = 1'b1; wdata = 32'h1234;
        step();
        hi_we = 1'b0;
        chk("mthi.hi", hi32, 32'h1234);
        chk("mthi.lo", lo32, 32'hFFFF_FFF1);
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hCAFE_0001;
        step();
        hi_we = 1'b0; lo_we = 1'b0;
        chk("mthilo.hi", hi32, 32'hCAFE_0001);
        chk("mthilo.lo", lo32, 32'hCAFE_0001);

        // start with MTHI/MTLO in the same cycle: writes are dropped.
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEAD_BEEF;
        run_op("start_wins", 1'b0, 2'b01, 32'h2, 32'h3, 32'h0, 32'h6, 1'b0, -1, 0, 1'b0);

        // Stall 5 cycles in RUN plus start/MTLO poked while busy.
        run_op("stall", 1'b0, 2'b01, 32'h0001_0003, 32'h0000_0007, 32'h0, 32'h0007_0015, 1'b0, 10, 5, 1'b1);

        // done/div_by_zero stretch across stalled cycles.
        run_op("dbz_stall", 1'b0, 2'b11, 32'h9, 32'h0, 32'h9, 32'hFFFF_FFFF, 1'b1, -1, 0, 1'b0);
        clk_enable = 1'b0;
        cnt = 0;
        repeat (3) begin
            step();
            if (done32 && dbz32) cnt++;
        end
        chk("stretch", cnt, 3);
        clk_enable = 1'b1;
        step();
        chk("stretch.end", {done32, dbz32}, 2'b00);

        // Reset mid-operation discards the result.
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h55;
        step();
        hi_we = 1'b0; lo_we = 1'b0;
        chk("preset.hilo", {hi32, lo32}, {32'h55, 32'h55});
        start = 1'b1; op = 2'b01; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
        step();
        start = 1'b0;
        repeat (9) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("abort.busy", busy32, 1'b0);
        chk("abort.hilo", {hi32, lo32}, 64'h0);
        chk("abort.done", done32, 1'b0);
        seen = 1'b0;
        repeat (50) begin
            step();
            if (done32) seen = 1'b1;
        end
        chk("abort.no_done", seen, 1'b0);

        // Randomized back-to-back operations at both widths.
        for (int w8 = 0; w8 < 2; w8++) begin
            for (int k = 0; k < 25; k++) begin
                o = 2'($urandom_range(0, 3));
                x = pick(w8 ? 8 : 32);
                y = pick(w8 ? 8 : 32);
                model(w8 ? 8 : 32, o, x, y, eh, el, ed);
                run_op($sformatf("rand%0d_%0d_op%0d_%0h_%0h", w8, k, o, x, y), w8[0], o, x, y,
                       eh, el, ed, -1, 0, 1'b0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
